// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tone_pkg
//  Description : Shared types and constants for the tone sequencer: FSM state
//                type, note-code enum and the half-period divider table.
//  Revision    : 1.0  initial release
// ============================================================================
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    // Codes 9..15 are not enumerated; they decode to a rest.
    typedef enum logic [3:0] {
        NOTE_REST  = 4'd0,
        NOTE_DO    = 4'd1,
        NOTE_RE    = 4'd2,
        NOTE_MI    = 4'd3,
        NOTE_FA    = 4'd4,
        NOTE_SO    = 4'd5,
        NOTE_LA    = 4'd6,
        NOTE_SI    = 4'd7,
        NOTE_DO_HI = 4'd8
    } note_e;

    // Half-period dividers in clk cycles (fits DIV_W = 16).
    localparam int unsigned c_DIV_DO    = 45801;
    localparam int unsigned c_DIV_RE    = 40815;
    localparam int unsigned c_DIV_MI    = 36363;
    localparam int unsigned c_DIV_FA    = 34322;
    localparam int unsigned c_DIV_SO    = 30578;
    localparam int unsigned c_DIV_LA    = 27242;
    localparam int unsigned c_DIV_SI    = 24270;
    localparam int unsigned c_DIV_DO_HI = 22944;

    // Divider for a note code; 0 means rest.
    function automatic int unsigned note_div(input logic [3:0] code);
        int unsigned div;
        case (code)
            4'd1:    div = c_DIV_DO;
            4'd2:    div = c_DIV_RE;
            4'd3:    div = c_DIV_MI;
            4'd4:    div = c_DIV_FA;
            4'd5:    div = c_DIV_SO;
            4'd6:    div = c_DIV_LA;
            4'd7:    div = c_DIV_SI;
            4'd8:    div = c_DIV_DO_HI;
            default: div = 0;
        endcase
        return div;
    endfunction

endpackage : tone_pkg
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// ============================================================================
//  Module      : song_rom
//  Description : Combinational song table. Each entry is {code[3:0],
//                dur[DUR_W-1:0]} with dur in beats. Indices at or beyond
//                SONG_LEN read as a one-beat rest.
//  Ports       : i_idx   - entry index
//                o_entry - {note code, duration}
//  Revision    : 1.0  initial release
// ============================================================================
module song_rom
    import tone_pkg::*;
#(
    parameter int SONG_LEN  = 29,
    parameter int DUR_W     = 3,
    parameter bit TEST_SONG = 1'b0
) (
    input  logic [7:0]       i_idx,
    output logic [DUR_W+3:0] o_entry
);

    function automatic logic [DUR_W+3:0] pack(input note_e code, input int unsigned dur);
        return {code, DUR_W'(dur)};
    endfunction

    always_comb begin
        o_entry = pack(NOTE_REST, 1);
        if (int'(i_idx) < SONG_LEN) begin
            if (TEST_SONG) begin
                // Short song used to exercise every playback path quickly.
                case (i_idx)
                    8'd0:    o_entry = pack(NOTE_DO,   1);
                    8'd1:    o_entry = pack(NOTE_REST, 2);
                    8'd2:    o_entry = pack(NOTE_SO,   0);
                    default: o_entry = pack(NOTE_REST, 1);
                endcase
            end else begin
                case (i_idx)
                    8'd0:    o_entry = pack(NOTE_DO,    1);
                    8'd1:    o_entry = pack(NOTE_DO,    1);
                    8'd2:    o_entry = pack(NOTE_SO,    1);
                    8'd3:    o_entry = pack(NOTE_SO,    1);
                    8'd4:    o_entry = pack(NOTE_LA,    1);
                    8'd5:    o_entry = pack(NOTE_LA,    1);
                    8'd6:    o_entry = pack(NOTE_SO,    2);
                    8'd7:    o_entry = pack(NOTE_FA,    1);
                    8'd8:    o_entry = pack(NOTE_FA,    1);
                    8'd9:    o_entry = pack(NOTE_MI,    1);
                    8'd10:   o_entry = pack(NOTE_MI,    1);
                    8'd11:   o_entry = pack(NOTE_RE,    1);
                    8'd12:   o_entry = pack(NOTE_RE,    1);
                    8'd13:   o_entry = pack(NOTE_DO,    2);
                    8'd14:   o_entry = pack(NOTE_REST,  1);
                    8'd15:   o_entry = pack(NOTE_SO,    1);
                    8'd16:   o_entry = pack(NOTE_SO,    1);
                    8'd17:   o_entry = pack(NOTE_FA,    1);
                    8'd18:   o_entry = pack(NOTE_FA,    1);
                    8'd19:   o_entry = pack(NOTE_MI,    1);
                    8'd20:   o_entry = pack(NOTE_MI,    1);
                    8'd21:   o_entry = pack(NOTE_RE,    2);
                    8'd22:   o_entry = pack(NOTE_SO,    1);
                    8'd23:   o_entry = pack(NOTE_SO,    1);
                    8'd24:   o_entry = pack(NOTE_FA,    1);
                    8'd25:   o_entry = pack(NOTE_FA,    1);
                    8'd26:   o_entry = pack(NOTE_MI,    1);
                    8'd27:   o_entry = pack(NOTE_RE,    1);
                    8'd28:   o_entry = pack(NOTE_DO_HI, 3);
                    default: o_entry = pack(NOTE_REST,  1);
                endcase
            end
        end
    end

endmodule : song_rom
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tone_sequencer
//  Description : Plays a song from song_rom as a square wave on o_buzzer.
//                IDLE -> LOAD (latch entry, 1 cycle) -> PLAY (beats) -> next.
//  Ports       : clk      - clock, rising edge
//                i_rst_n  - asynchronous active-low reset
//                i_start  - start request (level, honoured in IDLE)
//                i_stop   - abort, wins over start and end-of-song
//                i_loop   - restart at end of song instead of finishing
//                o_buzzer - tone output
//                o_busy   - high in LOAD and PLAY
//                o_done   - one-cycle pulse on non-looping completion
//                o_idx    - current song entry
//  Revision    : 1.0  initial release
// ============================================================================
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int          DIV_W       = 16,
    parameter int          BEAT_CYCLES = 12000000,
    parameter int          SONG_LEN    = 29,
    parameter int          DUR_W       = 3,
    parameter int unsigned DO_DIV      = c_DIV_DO,
    parameter bit          TEST_SONG   = 1'b0
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_loop,
    output logic       o_buzzer,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_idx
);

    localparam int                 c_BEAT_W    = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [7:0]         c_IDX_LAST  = 8'(SONG_LEN - 1);

    state_t               r_state_q, w_state_d;
    logic [7:0]           r_idx_q,   w_idx_d;
    logic [3:0]           r_code_q,  w_code_d;
    logic [DUR_W-1:0]     r_rem_q,   w_rem_d;
    logic [DIV_W-1:0]     r_tone_q,  w_tone_d;
    logic [c_BEAT_W-1:0]  r_beat_q,  w_beat_d;
    logic                 r_buzz_q,  w_buzz_d;
    logic                 r_done_q,  w_done_d;

    logic [DUR_W+3:0]     w_entry;
    logic [3:0]           w_rom_code;
    logic [DUR_W-1:0]     w_rom_dur;
    logic [DIV_W-1:0]     w_div;
    logic                 w_is_rest;
    logic                 w_beat_wrap;
    logic                 w_note_end;

    song_rom #(
        .SONG_LEN  (SONG_LEN),
        .DUR_W     (DUR_W),
        .TEST_SONG (TEST_SONG)
    ) u_song_rom (
        .i_idx   (r_idx_q),
        .o_entry (w_entry)
    );

    assign w_rom_code = w_entry[DUR_W+3:DUR_W];
    assign w_rom_dur  = w_entry[DUR_W-1:0];

    // DO may be overridden so a short divider can be used at low clock rates.
    assign w_div       = (r_code_q == NOTE_DO) ? DIV_W'(DO_DIV) : DIV_W'(note_div(r_code_q));
    assign w_is_rest   = (w_div == '0);
    assign w_beat_wrap = (r_beat_q == c_BEAT_LAST);
    // Remaining count of 1 at a beat wrap means this entry's last beat ends now.
    assign w_note_end  = w_beat_wrap && (r_rem_q == DUR_W'(1));

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_code_d  = r_code_q;
        w_rem_d   = r_rem_q;
        w_tone_d  = r_tone_q;
        w_beat_d  = r_beat_q;
        w_buzz_d  = r_buzz_q;
        w_done_d  = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                w_buzz_d = 1'b0;
                w_tone_d = '0;
                w_beat_d = '0;
                if (i_start && !i_stop) begin
                    w_state_d = ST_LOAD;
                    w_idx_d   = '0;
                end
            end

            ST_LOAD: begin
                w_buzz_d = 1'b0;
                w_tone_d = '0;
                w_beat_d = '0;
                if (i_stop) begin
                    w_state_d = ST_IDLE;
                    w_idx_d   = '0;
                end else begin
                    w_code_d  = w_rom_code;
                    // A zero duration still plays for one beat.
                    w_rem_d   = (w_rom_dur == '0) ? DUR_W'(1) : w_rom_dur;
                    w_state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (i_stop) begin
                    w_state_d = ST_IDLE;
                    w_idx_d   = '0;
                    w_buzz_d  = 1'b0;
                    w_tone_d  = '0;
                    w_beat_d  = '0;
                end else begin
                    if (w_is_rest) begin
                        w_tone_d = '0;
                        w_buzz_d = 1'b0;
                    end else if (r_tone_q == (w_div - DIV_W'(1))) begin
                        w_tone_d = '0;
                        w_buzz_d = ~r_buzz_q;
                    end else begin
                        w_tone_d = r_tone_q + DIV_W'(1);
                    end

                    if (w_beat_wrap) begin
                        w_beat_d = '0;
                        w_rem_d  = r_rem_q - DUR_W'(1);
                    end else begin
                        w_beat_d = r_beat_q + c_BEAT_W'(1);
                    end

                    if (w_note_end) begin
                        // Buzzer restarts low so every note begins in a known phase.
                        w_buzz_d = 1'b0;
                        if (r_idx_q != c_IDX_LAST) begin
                            w_idx_d   = r_idx_q + 8'd1;
                            w_state_d = ST_LOAD;
                        end else if (i_loop) begin
                            w_idx_d   = '0;
                            w_state_d = ST_LOAD;
                        end else begin
                            w_done_d  = 1'b1;
                            w_state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                w_state_d = ST_IDLE;
                w_idx_d   = '0;
                w_buzz_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= ST_IDLE;
            r_idx_q   <= '0;
            r_code_q  <= '0;
            r_rem_q   <= '0;
            r_tone_q  <= '0;
            r_beat_q  <= '0;
            r_buzz_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_code_q  <= w_code_d;
            r_rem_q   <= w_rem_d;
            r_tone_q  <= w_tone_d;
            r_beat_q  <= w_beat_d;
            r_buzz_q  <= w_buzz_d;
            r_done_q  <= w_done_d;
        end
    end

    assign o_buzzer = r_buzz_q;
    assign o_busy   = (r_state_q != ST_IDLE);
    assign o_done   = r_done_q;
    assign o_idx    = r_idx_q;

endmodule : tone_sequencer
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_sequencer
//  Description : Directed bench for tone_sequencer with BEAT_CYCLES=8, a
//                three-entry song {DO,1},{rest,2},{SO,0} and DO divider 3.
//                Timeline per song from the start edge E0: LOAD after E0,
//                entry 1 at E9, entry 2 at E26, end of song at E35.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tone_sequencer;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic       i_stop;
    logic       i_loop;
    logic       o_buzzer;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    tone_sequencer #(
        .DIV_W       (16),
        .BEAT_CYCLES (8),
        .SONG_LEN    (3),
        .DUR_W       (3),
        .DO_DIV      (3),
        .TEST_SONG   (1'b1)
    ) dut (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_stop   (i_stop),
        .i_loop   (i_loop),
        .o_buzzer (o_buzzer),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_idx    (o_idx)
    );

    always @(negedge clk) begin
        if (o_done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [8:0] buzz_exp;
        int hi;
        int dc;

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_loop  = 1'b0;
        tick(2);
        check("reset_busy",   32'(o_busy),   32'd0);
        check("reset_buzzer", 32'(o_buzzer), 32'd0);
        check("reset_done",   32'(o_done),   32'd0);
        check("reset_idx",    32'(o_idx),    32'd0);

        i_rst_n = 1'b1;
        tick(2);
        check("idle_wait_busy", 32'(o_busy), 32'd0);

        // ---- single play, no loop ----
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        check("start_busy", 32'(o_busy), 32'd1);
        check("start_idx",  32'(o_idx),  32'd0);

        // Buzzer after E1..E9: toggles at E4, E7; E9 forced low at note end.
        buzz_exp = 9'b000111000;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            check($sformatf("do_buzz_e%0d", k), 32'(o_buzzer), 32'(buzz_exp[9-k]));
            if (k == 8) check("idx_before_e9", 32'(o_idx), 32'd0);
        end
        check("idx_at_e9",  32'(o_idx),  32'd1);
        check("busy_at_e9", 32'(o_busy), 32'd1);

        tick(1);   // E10: LOAD -> PLAY of the rest entry
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (o_buzzer !== 1'b0) hi++;
            if (i == 14) check("rest_idx_e25", 32'(o_idx), 32'd1);
        end
        check("rest_quiet",  32'(hi),    32'd0);
        check("idx_at_e26",  32'(o_idx), 32'd2);

        dc = done_cnt;
        tick(8);   // E27..E34
        check("so_busy_e34", 32'(o_busy), 32'd1);
        check("so_done_e34", 32'(o_done), 32'd0);
        tick(1);   // E35
        check("end_done",   32'(o_done),   32'd1);
        check("end_busy",   32'(o_busy),   32'd0);
        check("end_buzzer", 32'(o_buzzer), 32'd0);
        tick(1);
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("done_pulses",    32'(done_cnt - dc), 32'd1);

        // ---- looping ----
        i_loop  = 1'b1;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        dc = done_cnt;
        for (int it = 0; it < 3; it++) begin
            tick(34);
            check($sformatf("loop%0d_idx_last", it), 32'(o_idx), 32'd2);
            tick(1);
            check($sformatf("loop%0d_idx_wrap", it), 32'(o_idx),  32'd0);
            check($sformatf("loop%0d_busy", it),     32'(o_busy), 32'd1);
        end
        check("loop_no_done", 32'(done_cnt - dc), 32'd0);

        // ---- stop mid-PLAY during the rest entry ----
        tick(12);
        check("pre_stop_idx", 32'(o_idx), 32'd1);
        i_stop = 1'b1;
        tick(1);
        i_stop = 1'b0;
        i_loop = 1'b0;
        check("stop_busy",   32'(o_busy),   32'd0);
        check("stop_idx",    32'(o_idx),    32'd0);
        check("stop_buzzer", 32'(o_buzzer), 32'd0);
        check("stop_done",   32'(o_done),   32'd0);

        // ---- stop together with start in IDLE ----
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick(2);
        check("stop_start_idle", 32'(o_busy), 32'd0);
        i_start = 1'b0;
        i_stop  = 1'b0;
        tick(1);

        // ---- async reset mid-note ----
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        tick(4);
        check("pre_reset_buzzer", 32'(o_buzzer), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_busy",   32'(o_busy),   32'd0);
        check("async_rst_buzzer", 32'(o_buzzer), 32'd0);
        check("async_rst_done",   32'(o_done),   32'd0);
        check("async_rst_idx",    32'(o_idx),    32'd0);
        tick(2);
        i_rst_n = 1'b1;
        tick(3);
        check("post_reset_idle", 32'(o_busy), 32'd0);

        // ---- replay from entry 0, start held across done ----
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        check("replay_busy", 32'(o_busy), 32'd1);
        check("replay_idx0", 32'(o_idx),  32'd0);
        tick(8);
        check("replay_idx_e8", 32'(o_idx), 32'd0);
        tick(1);
        check("replay_idx_e9", 32'(o_idx), 32'd1);
        tick(21);
        i_start = 1'b1;   // ignored while busy
        tick(4);
        check("busy_start_ignored_idx",  32'(o_idx),  32'd2);
        check("busy_start_ignored_busy", 32'(o_busy), 32'd1);
        tick(1);
        check("held_start_done", 32'(o_done), 32'd1);
        check("held_start_idle", 32'(o_busy), 32'd0);
        tick(1);
        check("held_start_restart", 32'(o_busy), 32'd1);
        check("held_start_idx",     32'(o_idx),  32'd0);
        i_start = 1'b0;
        i_stop  = 1'b1;
        tick(1);
        i_stop  = 1'b0;
        check("final_stop_busy", 32'(o_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tone_sequencer
`default_nettype wire
